// File: rtl/complemento_2.sv
// complemento_2: one-bit two's-complement slice (invert and add one via ripple carry) with registered copies
module complemento_2 (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic Cin,
  input  logic select,
  output logic R,
  output logic Cout,
  output logic R_q,
  output logic Cout_q
);
  // half-adder on the inverted bit in complement mode, straight pass-through otherwise
  always_comb begin
    R    = select ? (~A ^ Cin) : A;
    Cout = select ? (~A & Cin) : 1'b0;
  end
  // registered copy of the result for pipelined consumers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      R_q    <= 1'b0;
      Cout_q <= 1'b0;
    end else begin
      R_q    <= R;
      Cout_q <= Cout;
    end
endmodule

// File: tb/tb_complemento_2.sv
// tb_complemento_2: randomized and directed checks of a 4-slice chain and a free single slice against an arithmetic model
`timescale 1ps/1ps
module tb_complemento_2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] num = 4'd0;
  logic sel = 1'b0;
  logic a = 1'b0, cin = 1'b0, s = 1'b0;
  logic run = 1'b0;
  wire [4:0] cy;
  wire [3:0] r, rq, cq;
  wire r1, c1, rq1, cq1;
  int checks = 0;
  int errors = 0;
  assign cy[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_chain
    complemento_2 u_slice (
      .clk(clk), .rst(rst), .A(num[i]), .Cin(cy[i]), .select(sel),
      .R(r[i]), .Cout(cy[i+1]), .R_q(rq[i]), .Cout_q(cq[i])
    );
  end
  complemento_2 u_single (
    .clk(clk), .rst(rst), .A(a), .Cin(cin), .select(s),
    .R(r1), .Cout(c1), .R_q(rq1), .Cout_q(cq1)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  // chained result: negation modulo 16 or the number itself
  function automatic logic [3:0] m_r(input logic [3:0] n, input logic sl);
    return sl ? 4'(5'd16 - {1'b0, n}) : n;
  endfunction
  // carry out of slice i is set only when the +1 ripples through bits 0..i, i.e. those bits of n are all zero
  function automatic logic [3:0] m_c(input logic [3:0] n, input logic sl);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = sl && ((n & 4'((1 << (i + 1)) - 1)) == 4'd0);
    return v;
  endfunction
  // single slice as {carry, sum}: (not a) + cin in complement mode, a with no carry otherwise
  function automatic logic [1:0] m1(input logic av, input logic cv, input logic sv);
    return sv ? (2'({1'b0, ~av}) + 2'({1'b0, cv})) : {1'b0, av};
  endfunction
  logic [3:0] e_rq, e_cq;
  logic [1:0] e_q1;
  always @(posedge clk or posedge rst)
    if (rst) begin
      e_rq <= 4'd0;
      e_cq <= 4'd0;
      e_q1 <= 2'd0;
    end else begin
      e_rq <= m_r(num, sel);
      e_cq <= m_c(num, sel);
      e_q1 <= m1(a, cin, s);
    end
  always @(negedge clk)
    if (run) begin
      check("chain_r", r, m_r(num, sel));
      check("chain_cout", cy[4:1], m_c(num, sel));
      check("chain_r_q", rq, e_rq);
      check("chain_cout_q", cq, e_cq);
      check("slice", {2'b00, c1, r1}, {2'b00, m1(a, cin, s)});
      check("slice_q", {2'b00, cq1, rq1}, {2'b00, e_q1});
    end
  initial begin
    #1;
    check("reset_rq", rq, 4'd0);
    check("reset_cq", cq, 4'd0);
    check("reset_slice_q", {2'b00, cq1, rq1}, 4'd0);
    num = 4'b0101; sel = 1'b1; #1;
    check("neg_0101", r, 4'b1011);
    check("neg_0101_cout3", {3'b000, cy[4]}, 4'd0);
    num = 4'b0000; #1;
    check("neg_0000", r, 4'b0000);
    check("neg_0000_cout3", {3'b000, cy[4]}, 4'd1);
    num = 4'b1000; #1;
    check("neg_1000", r, 4'b1000);
    num = 4'b1111; #1;
    check("neg_1111", r, 4'b0001);
    num = 4'b1010; sel = 1'b0; #1;
    check("pass_1010", r, 4'b1010);
    check("pass_1010_cout", cy[4:1], 4'd0);
    a = 1'b0; cin = 1'b1; s = 1'b1; #1;
    check("slice_011", {2'b00, c1, r1}, 4'b0010);
    a = 1'b1; cin = 1'b1; s = 1'b1; #1;
    check("slice_111", {2'b00, c1, r1}, 4'b0001);
    a = 1'b1; cin = 1'b1; s = 1'b0; #1;
    check("slice_110", {2'b00, c1, r1}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    for (int sl = 0; sl < 2; sl++)
      for (int n = 0; n < 16; n++) begin
        @(posedge clk);
        #2;
        num = 4'(n);
        sel = 1'(sl);
        {a, cin, s} = 3'(n);
      end
    @(posedge clk);
    #2;
    a = 1'b0; cin = 1'b1; s = 1'b1;
    @(posedge clk);
    #1;
    check("reg_load", {2'b00, cq1, rq1}, 4'b0010);
    #1 rst = 1'b1;
    #1;
    check("reg_async_clear", {2'b00, cq1, rq1}, 4'd0);
    check("comb_during_reset", {2'b00, c1, r1}, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reg_reload", {2'b00, cq1, rq1}, 4'b0010);
    repeat (300) begin
      @(posedge clk);
      #2;
      num = 4'($urandom);
      sel = 1'($urandom);
      {a, cin, s} = 3'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      if (!rst && $urandom_range(0, 7) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
